// File: rtl/multi_pulse_sync_pkg.sv
// multi_pulse_sync_pkg: edge-mode encodings and a constant clog2 helper shared by the synchroniser
package multi_pulse_sync_pkg;
  localparam logic [1:0] MODE_ANY  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/multi_pulse_sync_if.sv
// multi_pulse_sync_if: event lines, mode/clear controls and per-channel results of the synchroniser
interface multi_pulse_sync_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic [CH-1:0]       async_in;
  logic [2*CH-1:0]     edge_mode;
  logic [CH-1:0]       cnt_clr;
  logic [CH-1:0]       level_out;
  logic [CH-1:0]       pulse_out;
  logic [CH*CNT_W-1:0] evt_cnt;
  logic [CH-1:0]       ovf;
  modport master (output async_in, edge_mode, cnt_clr, input level_out, pulse_out, evt_cnt, ovf);
  modport slave  (input async_in, edge_mode, cnt_clr, output level_out, pulse_out, evt_cnt, ovf);
endinterface

// File: rtl/multi_pulse_sync_ch.sv
// pulse_sync_ch: one channel - sync chain, optional glitch filter, edge detect, saturating counter
module pulse_sync_ch
  import multi_pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             async_in,
  input  logic [1:0]       edge_mode,
  input  logic             cnt_clr,
  output logic             level_out,
  output logic             pulse_out,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf
);
  logic [SYNC_STAGES-1:0] sync;
  logic sync_q, level_nxt, hit;
  always_ff @(posedge clk) sync <= rst ? '0 : {sync[SYNC_STAGES-2:0], async_in};
  assign sync_q = sync[SYNC_STAGES-1];
  if (FILT == 0) begin : g_nofilt
    assign level_nxt = sync_q;
  end else begin : g_filt
    localparam int FW = clog2(FILT + 1);
    logic [FW-1:0] fcnt;
    logic          full;
    assign full = fcnt == FW'(FILT);
    always_ff @(posedge clk) fcnt <= (rst || sync_q == level_out || full) ? '0 : fcnt + 1'b1;
    assign level_nxt = (sync_q != level_out && full) ? sync_q : level_out;
  end
  assign hit = (level_nxt != level_out) &&
               (edge_mode == MODE_ANY || (edge_mode == MODE_RISE && level_nxt) ||
                (edge_mode == MODE_FALL && !level_nxt));
  always_ff @(posedge clk) begin
    if (rst) begin
      level_out <= 1'b0;
      pulse_out <= 1'b0;
      evt_cnt   <= '0;
      ovf       <= 1'b0;
    end else begin
      level_out <= level_nxt;
      pulse_out <= hit;
      if (cnt_clr) begin
        evt_cnt <= CNT_W'(pulse_out);
        ovf     <= 1'b0;
      end else if (pulse_out) begin
        evt_cnt <= &evt_cnt ? evt_cnt : evt_cnt + 1'b1;
        ovf     <= ovf | (&evt_cnt);
      end
    end
  end
endmodule

// File: rtl/multi_pulse_sync.sv
// multi_pulse_sync: CH independent asynchronous event lines synchronised into the clk domain
module multi_pulse_sync
  import multi_pulse_sync_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 0,
  parameter int CNT_W       = 8
) (
  input logic              clk,
  input logic              rst,
  multi_pulse_sync_if.slave bus
);
  for (genvar i = 0; i < CH; i++) begin : g_ch
    pulse_sync_ch #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT), .CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .async_in  (bus.async_in[i]),
      .edge_mode (bus.edge_mode[2*i +: 2]),
      .cnt_clr   (bus.cnt_clr[i]),
      .level_out (bus.level_out[i]),
      .pulse_out (bus.pulse_out[i]),
      .evt_cnt   (bus.evt_cnt[CNT_W*i +: CNT_W]),
      .ovf       (bus.ovf[i])
    );
  end
endmodule

// File: tb/tb_multi_pulse_sync.sv
// tb_multi_pulse_sync: two configurations (unfiltered/2-bit count, filtered/8-bit count) against a window model
module tb_multi_pulse_sync;
  import multi_pulse_sync_pkg::*;
  localparam int CH = 4, S = 2, FA = 0, WA = 2, FB = 3, WB = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [CH-1:0] ain = '0, clr = '0;
  logic [2*CH-1:0] mode = '0;
  int total = 0, bad = 0;
  logic [CH-1:0] hist[$], chq[$];
  logic [CH-1:0] lvl_m[2], pul_m[2], ovf_m[2];
  int cnt_m[2][CH];
  int filt_m[2] = '{FA, FB};
  int max_m[2] = '{(1 << WA) - 1, (1 << WB) - 1};
  always #5 clk = ~clk;
  multi_pulse_sync_if #(.CH(CH), .CNT_W(WA)) ia ();
  multi_pulse_sync_if #(.CH(CH), .CNT_W(WB)) ib ();
  multi_pulse_sync #(.CH(CH), .SYNC_STAGES(S), .FILT(FA), .CNT_W(WA)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  multi_pulse_sync #(.CH(CH), .SYNC_STAGES(S), .FILT(FB), .CNT_W(WB)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  assign ia.async_in = ain;
  assign ib.async_in = ain;
  assign ia.edge_mode = mode;
  assign ib.edge_mode = mode;
  assign ia.cnt_clr = clr;
  assign ib.cnt_clr = clr;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Level flips once the last FILT+1 chain samples all disagree with it.
  task automatic model();
    logic flip;
    logic [1:0] m;
    if (rst) begin
      hist.delete();
      chq.delete();
      for (int j = 0; j < 8; j++) begin
        hist.push_back('0);
        chq.push_back('0);
      end
      for (int d = 0; d < 2; d++) begin
        lvl_m[d] = '0;
        pul_m[d] = '0;
        ovf_m[d] = '0;
        for (int i = 0; i < CH; i++) cnt_m[d][i] = 0;
      end
      return;
    end
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < CH; i++) begin
        if (clr[i]) begin
          cnt_m[d][i] = pul_m[d][i] ? 1 : 0;
          ovf_m[d][i] = 1'b0;
        end else if (pul_m[d][i]) begin
          if (cnt_m[d][i] == max_m[d]) ovf_m[d][i] = 1'b1;
          else cnt_m[d][i]++;
        end
        flip = 1'b1;
        for (int j = 0; j <= filt_m[d]; j++)
          if (chq[chq.size() - 1 - j][i] == lvl_m[d][i]) flip = 1'b0;
        m = mode[2*i +: 2];
        pul_m[d][i] = flip && (m == MODE_ANY || (m == MODE_RISE && !lvl_m[d][i]) ||
                               (m == MODE_FALL && lvl_m[d][i]));
        if (flip) lvl_m[d][i] = ~lvl_m[d][i];
      end
    end
    hist.push_back(ain);
    chq.push_back(hist[hist.size() - S]);
    while (hist.size() > 16) void'(hist.pop_front());
    while (chq.size() > 16) void'(chq.pop_front());
  endtask
  task automatic check_all();
    chk("a_level", 32'(ia.level_out), 32'(lvl_m[0]));
    chk("a_pulse", 32'(ia.pulse_out), 32'(pul_m[0]));
    chk("a_ovf", 32'(ia.ovf), 32'(ovf_m[0]));
    chk("b_level", 32'(ib.level_out), 32'(lvl_m[1]));
    chk("b_pulse", 32'(ib.pulse_out), 32'(pul_m[1]));
    chk("b_ovf", 32'(ib.ovf), 32'(ovf_m[1]));
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("a_cnt%0d", i), 32'(ia.evt_cnt[WA*i +: WA]), 32'(cnt_m[0][i]));
      chk($sformatf("b_cnt%0d", i), 32'(ib.evt_cnt[WB*i +: WB]), 32'(cnt_m[1][i]));
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model();
      @(negedge clk);
      check_all();
    end
  endtask
  initial begin
    tick(3);
    chk("rst_a_out", 32'({ia.level_out, ia.pulse_out, ia.ovf}), 32'd0);
    chk("rst_b_cnt", 32'(ib.evt_cnt), 32'd0);
    rst = 1'b0;
    tick(5);
    ain[0] = 1'b1;
    tick(2);
    chk("any_a_early", 32'(ia.pulse_out[0]), 32'd0);
    tick(1);
    chk("any_a_pulse", 32'(ia.pulse_out[0]), 32'd1);
    chk("any_a_level", 32'(ia.level_out[0]), 32'd1);
    tick(1);
    chk("any_a_single", 32'(ia.pulse_out[0]), 32'd0);
    chk("any_a_cnt", 32'(ia.evt_cnt[0 +: WA]), 32'd1);
    tick(1);
    chk("filt_b_early", 32'(ib.pulse_out[0]), 32'd0);
    tick(1);
    chk("filt_b_pulse", 32'(ib.pulse_out[0]), 32'd1);
    mode[1:0] = MODE_RISE;
    ain[0] = 1'b0;
    tick(10);
    ain[0] = 1'b1;
    tick(2);
    ain[0] = 1'b0;
    tick(10);
    chk("glitch_b_level", 32'(ib.level_out[0]), 32'd0);
    chk("glitch_b_cnt", 32'(ib.evt_cnt[0 +: WB]), 32'd1);
    ain[0] = 1'b1;
    tick(5);
    chk("rise_b_early", 32'(ib.pulse_out[0]), 32'd0);
    tick(1);
    chk("rise_b_pulse", 32'(ib.pulse_out[0]), 32'd1);
    chk("rise_b_level", 32'(ib.level_out[0]), 32'd1);
    tick(4);
    mode[3:2] = MODE_FALL;
    mode[5:4] = MODE_OFF;
    ain[2:1] = 2'b11;
    tick(8);
    chk("fall_a_cnt1_rise", 32'(ia.evt_cnt[WA*1 +: WA]), 32'd0);
    chk("off_a_level2", 32'(ia.level_out[2]), 32'd1);
    ain[2:1] = 2'b00;
    tick(8);
    chk("fall_a_cnt1", 32'(ia.evt_cnt[WA*1 +: WA]), 32'd1);
    chk("off_b_cnt2", 32'(ib.evt_cnt[WB*2 +: WB]), 32'd0);
    mode[7:6] = MODE_RISE;
    repeat (5) begin
      ain[3] = 1'b1;
      tick(6);
      ain[3] = 1'b0;
      tick(6);
    end
    chk("sat_a_cnt3", 32'(ia.evt_cnt[WA*3 +: WA]), 32'd3);
    chk("sat_a_ovf3", 32'(ia.ovf[3]), 32'd1);
    chk("sat_b_cnt3", 32'(ib.evt_cnt[WB*3 +: WB]), 32'd5);
    ain[3] = 1'b1;
    tick(3);
    chk("clr_a_pulse3", 32'(ia.pulse_out[3]), 32'd1);
    clr[3] = 1'b1;
    tick(1);
    clr[3] = 1'b0;
    chk("clr_a_cnt3", 32'(ia.evt_cnt[WA*3 +: WA]), 32'd1);
    chk("clr_a_ovf3", 32'(ia.ovf[3]), 32'd0);
    tick(6);
    mode = '0;
    ain = ~ain;
    tick(3);
    chk("all_a_pulse", 32'(ia.pulse_out), 32'hf);
    tick(3);
    chk("all_b_pulse", 32'(ib.pulse_out), 32'hf);
    ain = '0;
    tick(10);
    rst = 1'b1;
    ain[0] = 1'b1;
    tick(2);
    chk("rst_hold_a", 32'({ia.level_out, ia.pulse_out, ia.ovf, ia.evt_cnt}), 32'd0);
    rst = 1'b0;
    tick(2);
    chk("rel_a_early", 32'(ia.pulse_out[0]), 32'd0);
    tick(1);
    chk("rel_a_pulse", 32'(ia.pulse_out[0]), 32'd1);
    tick(6);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) ain[$urandom_range(0, CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 40) == 0) mode = (2*CH)'($urandom);
      clr = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
      if (n == 200) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_a", 32'({ia.level_out, ia.pulse_out, ia.ovf, ia.evt_cnt}), 32'd0);
        chk("mid_rst_b", 32'({ib.level_out, ib.pulse_out, ib.ovf}), 32'd0);
        chk("mid_rst_bcnt", 32'(ib.evt_cnt), 32'd0);
      end
      tick(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_pulse_sync.md
# multi_pulse_sync

Multi-channel receive-side event synchroniser that sits in the destination clock domain, capturing up to CH asynchronous event lines. Each line is a toggle or level signal driven from a foreign clock domain. For every channel the block provides:
- a metastability-hardened chain of configurable depth,
- an optional glitch filter,
- a per-channel runtime edge-mode select,
- a single-cycle event pulse,
- a saturating event counter with a sticky overflow flag.

It replaces fixed single-channel toggle-to-pulse synchronisers wherever several event lines cross into one clock domain.

## Interface
Parameters:
- CH, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, flops in each synchroniser chain (≥2)
- FILT, 0, consecutive stable cycles required before the filtered level follows the synced input (0 = filter bypassed)
- CNT_W, 8, event counter width per channel (≥1)

Ports:
- clk  in  1  destination clock; the only clock in the block
- rst  in  1  synchronous, active-high reset
- async_in  in  CH  asynchronous event lines, one bit per channel
- edge_mode  in  2*CH  per-channel mode, bits [2i+1:2i] for channel i: 00 any edge (toggle protocol), 01 rising, 10 falling, 11 pulses disabled
- cnt_clr  in  CH  per-channel synchronous clear of evt_cnt and ovf
- level_out  out  CH  synchronised, filtered level; usable as the return-ack toggle to the source domain
- pulse_out  out  CH  one-cycle event strobe
- evt_cnt  out  CH*CNT_W  per-channel event count, bits [CNT_W*(i+1)-1:CNT_W*i]
- ovf  out  CH  sticky counter-saturation flag

## Operation
- All outputs and internal state reset to 0, including every sync flop and filter counter.
  - If async_in[i] is high when reset is released, channel i sees a rising transition and reports it after normal latency. This is intended behaviour.
- Sync chain: async_in[i] → SYNC_STAGES flops. No logic is permitted between chain flops.
- Filter, FILT>0:
  - A per-channel counter of width clog2(FILT+1) increments each cycle the chain output differs from level_out[i].
  - When the counter reaches FILT, level_out[i] takes the chain output and the counter clears.
  - The counter clears whenever the chain output equals level_out[i].
- Filter, FILT=0: level_out[i] is a single register following the chain output.
- Edge detection compares the next level against the current level.
  - pulse_out[i] is registered and asserts on the same edge at which level_out[i] changes, provided the edge matches edge_mode.
  - Mode 11 suppresses the pulse; level_out still tracks.
- edge_mode is sampled every cycle. A change takes effect at the next edge; no pending event is re-evaluated.
- Counter:
  - Increments on each pulse_out.
  - At all-ones it holds and sets ovf[i].
  - cnt_clr[i] clears the count and ovf[i].
  - If cnt_clr and a pulse occur in the same cycle, the result is count=1 and ovf=0. The event is never lost.
- Channels are fully independent. Simultaneous events on any number of channels are all reported in the same cycle.

## Timing
- Let an input transition be first captured at edge k and held stable.
  - The chain output changes at edge k+SYNC_STAGES-1.
  - level_out and pulse_out change at edge k+SYNC_STAGES+FILT.
  - evt_cnt updates one edge later.
- Capture uncertainty is ±1 cycle (asynchronous input).
- Source-side rule:
  - Toggle protocol (mode 00): the source must not toggle again until it sees level_out[i] equal to its toggle, i.e. a four-phase-free ack loop.
  - Level protocols: the source must hold each level for ≥SYNC_STAGES+FILT+1 destination cycles. Shorter excursions may be filtered away or merged; this is not an error.
- Pulses the filter rejects produce no pulse and no count.
- Reset asserted mid-operation clears everything at the next edge. Pulses and counts in flight are discarded.

## Structure
- Shared package multi_pulse_sync_pkg holds:
  - the edge-mode localparams: MODE_ANY=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_OFF=2'b11
  - a clog2 helper function
- Sub-module pulse_sync_ch implements one channel: chain, filter, edge detect, counter. The top instantiates it CH times with a generate loop and handles only slicing of the packed buses.

## Test plan
- SYNC_STAGES=2, FILT=0, mode 00: toggle async_in[0] 0→1 at cycle 10 → level_out[0]=1 and pulse_out[0] for one cycle at edge 12±1; evt_cnt[0]=1 one edge later.
- FILT=3, mode 01: 2-cycle high glitch → no pulse, count 0. Then a 10-cycle high → one pulse at k+5, level_out=1.
- Mode 10 on ch1 and mode 11 on ch2, same input waveform 0→1→0 → ch1 pulses on the fall only, ch2 never pulses, ch2 level_out still tracks.
- CNT_W=2: five rising events on ch3 → evt_cnt holds 3 and ovf=1. cnt_clr coincident with the sixth pulse → count=1, ovf=0.
- All CH channels toggle in the same cycle → all pulse_out assert together; counts independent.
- Reset while async_in=1'b1 on ch0, then release → rising pulse after SYNC_STAGES+FILT+1 cycles. Reset pulsed mid-count → all outputs 0 next edge.
